// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - subroutine return-address stack and PC-load source for the program counter
// Optional sticky overflow/underflow flags are built when PC_STACK_FLAGS_EN is defined.
module pc_stack #(
  parameter int DEPTH = 3,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cycle,
  input  logic [AW-1:0] pcAddr,
  input  logic          jumpReq,
  input  logic          pushReq,
  input  logic          popReq,
  input  logic [AW-1:0] target,
  output logic          pcLoad,
  output logic [AW-1:0] pcNew,
  output logic [1:0]    depth,
  output logic          stkOvf,
  output logic          stkUnf,
  input  logic          clrFlags
);

  localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_MAX   = PW'(DEPTH - 1);
  localparam logic [1:0]      DEPTH_MAX = 2'(DEPTH);
  localparam logic [2:0]      CYC_X3    = 3'd7;

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] ptr_inc, ptr_dec;
  logic [1:0]    depth_q, depth_d;

  logic at_x3;
  logic do_pop, do_push, do_jump;
  logic ovf_evt, unf_evt;

  // Requests are only honoured in X3; pop outranks push, push outranks jump.
  assign at_x3   = (cycle == CYC_X3);
  assign do_pop  = ~rst & at_x3 & popReq;
  assign do_push = ~rst & at_x3 & pushReq & ~popReq;
  assign do_jump = ~rst & at_x3 & jumpReq & ~popReq & ~pushReq;

  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;

  assign ovf_evt = do_push & (depth_q == DEPTH_MAX);
  assign unf_evt = do_pop & (depth_q == 2'd0);

  assign pcLoad = do_pop | do_push | do_jump;
  assign pcNew  = do_pop ? mem_q[ptr_dec] : target;
  assign depth  = depth_q;

  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    if (do_pop) begin
      ptr_d = ptr_dec;
      if (depth_q != 2'd0) begin
        depth_d = depth_q - 2'd1;
      end
    end else if (do_push) begin
      ptr_d = ptr_inc;
      if (depth_q != DEPTH_MAX) begin
        depth_d = depth_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      depth_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      // On overflow the slot at ptr holds the oldest entry, so it is simply overwritten.
      if (do_push) begin
        mem_q[ptr_q] <= pcAddr;
      end
    end
  end

`ifdef PC_STACK_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clrFlags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_evt) ovf_d = 1'b1;
    if (unf_evt) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign stkOvf = ovf_q;
  assign stkUnf = unf_q;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = clrFlags ^ ovf_evt ^ unf_evt;
  assign stkOvf = 1'b0;
  assign stkUnf = 1'b0;
`endif

endmodule
